// File: rtl/fifo_pkg.sv
// Shared defaults and the skid-buffer occupancy type for the read side of the dual-clock fifo.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned CNT_WIDTH_DEF  = 16;
    localparam int unsigned SEQ_START_DEF  = 1;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_count_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer: entries leave in arrival order, and the head word stays stable
// until it is popped.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] pushData_i,
    input  logic                  pop_i,
    output logic [1:0]            count_o,
    output logic [DATA_WIDTH-1:0] headData_o
);

    skid_count_t           count_q, count_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  doPush;
    logic                  doPop;

    // A full buffer only accepts a word when the head leaves on the same edge.
    assign doPop  = pop_i && (count_q != SKID_EMPTY);
    assign doPush = push_i && ((count_q != SKID_FULL) || doPop);

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (count_q)
            SKID_EMPTY: begin
                if (doPush) begin
                    head_d  = pushData_i;
                    count_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (doPush && doPop) begin
                    head_d = pushData_i;
                end else if (doPush) begin
                    tail_d  = pushData_i;
                    count_d = SKID_FULL;
                end else if (doPop) begin
                    count_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (doPop) begin
                    head_d = tail_q;
                    if (doPush) begin
                        tail_d = pushData_i;
                    end else begin
                        count_d = SKID_ONE;
                    end
                end
            end
            default: begin
                count_d = SKID_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= SKID_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign count_o    = count_q;
    assign headData_o = head_q;

endmodule

// File: rtl/fifo_reader.sv
// Read-side consumer of the dual-clock fifo: pops words into a skid buffer and serves them
// on valid/ready. Define FIFO_READER_SEQCHK_EN to build the incrementing-sequence checker.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = DATA_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] SEQ_START  = DATA_WIDTH'(SEQ_START_DEF),
    parameter int unsigned           CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clock_out,
    input  logic                  rst_out,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_valid,
    output logic                  fifo_ack,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  seq_err,
    output logic [CNT_WIDTH-1:0]  err_count
);

    logic [1:0]           skidCount;
    logic                 pushEn;
    logic                 popEn;
    logic [CNT_WIDTH-1:0] wordCount_q, wordCount_d;

    // The ack depends only on registered occupancy and local controls, which keeps the fifo
    // handshake free of combinational loops.
    assign fifo_ack = !rst_out && enable && (skidCount < SKID_FULL);
    assign pushEn   = fifo_valid && fifo_ack;
    assign popEn    = rd_valid && rd_ready;
    assign rd_valid = (skidCount != SKID_EMPTY);

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk_i      (clock_out),
        .rst_i      (rst_out),
        .push_i     (pushEn),
        .pushData_i (fifo_data),
        .pop_i      (popEn),
        .count_o    (skidCount),
        .headData_o (rd_data)
    );

    always_comb begin
        wordCount_d = wordCount_q;
        if (pushEn && (wordCount_q != '1)) begin
            wordCount_d = wordCount_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock_out) begin
        if (rst_out) begin
            wordCount_q <= '0;
        end else begin
            wordCount_q <= wordCount_d;
        end
    end

    assign word_count = wordCount_q;

`ifdef FIFO_READER_SEQCHK_EN
    logic [DATA_WIDTH-1:0] expected_q, expected_d;
    logic                  seqErr_q, seqErr_d;
    logic [CNT_WIDTH-1:0]  errCount_q, errCount_d;

    // Always resync to the received word so that a gap costs exactly one error.
    always_comb begin
        expected_d = expected_q;
        seqErr_d   = seqErr_q;
        errCount_d = errCount_q;
        if (pushEn) begin
            expected_d = fifo_data + DATA_WIDTH'(1);
            if (fifo_data != expected_q) begin
                seqErr_d = 1'b1;
                if (errCount_q != '1) begin
                    errCount_d = errCount_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock_out) begin
        if (rst_out) begin
            expected_q <= SEQ_START;
            seqErr_q   <= 1'b0;
            errCount_q <= '0;
        end else begin
            expected_q <= expected_d;
            seqErr_q   <= seqErr_d;
            errCount_q <= errCount_d;
        end
    end

    assign seq_err   = seqErr_q;
    assign err_count = errCount_q;
`else
    logic [DATA_WIDTH-1:0] unusedSeqStart;

    assign unusedSeqStart = SEQ_START;
    assign seq_err        = 1'b0;
    assign err_count      = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: a fifo source model feeds a scoreboard of accepted words,
// and scenario tasks check handshake, counters and the optional sequence checker.
module tb_fifo_reader;

   localparam int DW = 32;
   localparam int CW = 16;
`ifdef FIFO_READER_SEQCHK_EN
   localparam int SEQCHK = 1;
`else
   localparam int SEQCHK = 0;
`endif

   logic          clk;
   logic          rst;
   logic          enable;
   logic [DW-1:0] fifoData;
   logic          fifoValid;
   logic          fifoAck;
   logic [DW-1:0] rdData;
   logic          rdValid;
   logic          rdReady;
   logic [CW-1:0] wordCount;
   logic          seqErr;
   logic [CW-1:0] errCount;

   logic          enable8;
   logic [7:0]    fifoData8;
   logic          fifoValid8;
   logic          fifoAck8;
   logic [7:0]    rdData8;
   logic          rdValid8;
   logic          rdReady8;
   logic [CW-1:0] wordCount8;
   logic          seqErr8;
   logic [CW-1:0] errCount8;

   int            compared;
   int            mismatched;
   int            popCount;
   logic          srcEn;
   logic [DW-1:0] srcQ[$];
   logic [DW-1:0] expQ[$];

   fifo_reader #(.DATA_WIDTH(DW), .SEQ_START(32'd1), .CNT_WIDTH(CW)) dut (
      .clock_out (clk),
      .rst_out   (rst),
      .enable    (enable),
      .fifo_data (fifoData),
      .fifo_valid(fifoValid),
      .fifo_ack  (fifoAck),
      .rd_data   (rdData),
      .rd_valid  (rdValid),
      .rd_ready  (rdReady),
      .word_count(wordCount),
      .seq_err   (seqErr),
      .err_count (errCount)
   );

   fifo_reader #(.DATA_WIDTH(8), .SEQ_START(8'hFE), .CNT_WIDTH(CW)) dut8 (
      .clock_out (clk),
      .rst_out   (rst),
      .enable    (enable8),
      .fifo_data (fifoData8),
      .fifo_valid(fifoValid8),
      .fifo_ack  (fifoAck8),
      .rd_data   (rdData8),
      .rd_valid  (rdValid8),
      .rd_ready  (rdReady8),
      .word_count(wordCount8),
      .seq_err   (seqErr8),
      .err_count (errCount8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Source model and scoreboard: on each falling edge present the next source word, then
   // account for the transfers that the coming rising edge will perform.
   task automatic runScoreboard();
      logic [DW-1:0] exp;
      forever begin
         @(negedge clk);
         fifoValid = srcEn && (srcQ.size() != 0);
         fifoData  = (srcQ.size() != 0) ? srcQ[0] : '0;
         if (rst) begin
            expQ.delete();
         end else begin
            if (rdValid && rdReady) begin
               compared++;
               if (expQ.size() == 0) begin
                  mismatched++;
                  $display("[TB] FAIL sb_underflow: got word %0h, expected no word", rdData);
               end else begin
                  exp = expQ.pop_front();
                  popCount++;
                  if (rdData !== exp) begin
                     mismatched++;
                     $display("[TB] FAIL sb_data: got %0h expected %0h", rdData, exp);
                  end
               end
            end
            if (fifoValid && fifoAck) begin
               expQ.push_back(srcQ.pop_front());
            end
         end
      end
   endtask

   task automatic applyReset();
      @(posedge clk); #1;
      rst        = 1'b1;
      srcEn      = 1'b0;
      srcQ.delete();
      rdReady    = 1'b0;
      fifoValid8 = 1'b0;
      rdReady8   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b1; enable8 = 1'b1; rdReady = 1'b0; rdReady8 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      compared++; if (fifoAck !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ack: got %b expected 0", fifoAck); end
      compared++; if (fifoAck8 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ack8: got %b expected 0", fifoAck8); end
      compared++; if (rdValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", rdValid); end
      compared++; if (rdData !== '0) begin mismatched++; $display("[TB] FAIL reset_data: got %0h expected 0", rdData); end
      compared++; if (wordCount !== '0) begin mismatched++; $display("[TB] FAIL reset_wcnt: got %0d expected 0", wordCount); end
      compared++; if (seqErr !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_seqerr: got %b expected 0", seqErr); end
      compared++; if (errCount !== '0) begin mismatched++; $display("[TB] FAIL reset_errcnt: got %0d expected 0", errCount); end
      rst = 1'b0;
      #1;
      compared++; if (fifoAck !== 1'b1) begin mismatched++; $display("[TB] FAIL release_ack: got %b expected 1", fifoAck); end
   endtask

   task automatic test_stream();
      int startPop;
      applyReset();
      enable = 1'b1; rdReady = 1'b1;
      for (int v = 1; v <= 8; v++) srcQ.push_back(DW'(v));
      startPop = popCount;
      srcEn = 1'b1;
      compared++; if (rdValid !== 1'b0) begin mismatched++; $display("[TB] FAIL stream_idle: got %b expected 0", rdValid); end
      @(posedge clk); #1;
      for (int k = 1; k <= 8; k++) begin
         compared++;
         if (rdValid !== 1'b1 || rdData !== DW'(k)) begin
            mismatched++;
            $display("[TB] FAIL stream_beat: got valid %b data %0h expected valid 1 data %0h", rdValid, rdData, k);
         end
         @(posedge clk); #1;
      end
      srcEn = 1'b0;
      compared++; if (rdValid !== 1'b0) begin mismatched++; $display("[TB] FAIL stream_end: got %b expected 0", rdValid); end
      compared++; if (wordCount !== CW'(8)) begin mismatched++; $display("[TB] FAIL stream_wcnt: got %0d expected 8", wordCount); end
      compared++; if (popCount - startPop !== 8) begin mismatched++; $display("[TB] FAIL stream_pops: got %0d expected 8", popCount - startPop); end
      compared++; if (seqErr !== 1'b0) begin mismatched++; $display("[TB] FAIL stream_seqerr: got %b expected 0", seqErr); end
   endtask

   task automatic test_backpressure();
      int startPop;
      applyReset();
      enable = 1'b1; rdReady = 1'b0;
      for (int v = 1; v <= 6; v++) srcQ.push_back(DW'(v));
      startPop = popCount;
      srcEn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      compared++; if (fifoAck !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_ack_full: got %b expected 0", fifoAck); end
      compared++; if (rdValid !== 1'b1 || rdData !== DW'(1)) begin mismatched++; $display("[TB] FAIL bp_head: got valid %b data %0h expected 1/1", rdValid, rdData); end
      @(posedge clk); #1;
      compared++; if (rdData !== DW'(1)) begin mismatched++; $display("[TB] FAIL bp_hold: got %0h expected 1", rdData); end
      rdReady = 1'b1;
      for (int c = 0; c < 100; c++) begin
         if (srcQ.size() == 0 && expQ.size() == 0) break;
         @(posedge clk);
      end
      #1;
      compared++; if (srcQ.size() != 0 || expQ.size() != 0) begin mismatched++; $display("[TB] FAIL bp_drain: got %0d words left expected 0", srcQ.size() + expQ.size()); end
      compared++; if (popCount - startPop !== 6) begin mismatched++; $display("[TB] FAIL bp_pops: got %0d expected 6", popCount - startPop); end
      compared++; if (wordCount !== CW'(6)) begin mismatched++; $display("[TB] FAIL bp_wcnt: got %0d expected 6", wordCount); end
      srcEn = 1'b0;
   endtask

   task automatic test_seq_gap();
      logic [DW-1:0] stream[6] = '{32'd1, 32'd2, 32'd3, 32'd7, 32'd8, 32'd9};
      applyReset();
      enable = 1'b1; rdReady = 1'b1;
      foreach (stream[i]) srcQ.push_back(stream[i]);
      srcEn = 1'b1;
      for (int c = 0; c < 100; c++) begin
         if (srcQ.size() == 0 && expQ.size() == 0) break;
         @(posedge clk);
      end
      #1;
      compared++; if (srcQ.size() != 0 || expQ.size() != 0) begin mismatched++; $display("[TB] FAIL gap_drain: got %0d words left expected 0", srcQ.size() + expQ.size()); end
      compared++; if (seqErr !== 1'(SEQCHK)) begin mismatched++; $display("[TB] FAIL gap_seqerr: got %b expected %0d", seqErr, SEQCHK); end
      compared++; if (errCount !== CW'(SEQCHK)) begin mismatched++; $display("[TB] FAIL gap_errcnt: got %0d expected %0d", errCount, SEQCHK); end
      compared++; if (wordCount !== CW'(6)) begin mismatched++; $display("[TB] FAIL gap_wcnt: got %0d expected 6", wordCount); end
      repeat (3) @(posedge clk);
      #1;
      compared++; if (seqErr !== 1'(SEQCHK)) begin mismatched++; $display("[TB] FAIL gap_sticky: got %b expected %0d", seqErr, SEQCHK); end
      srcEn = 1'b0;
   endtask

   task automatic test_enable_drop();
      applyReset();
      enable = 1'b1; rdReady = 1'b0;
      #1;
      compared++; if (fifoAck !== 1'b1) begin mismatched++; $display("[TB] FAIL en_ack_on: got %b expected 1", fifoAck); end
      enable = 1'b0;
      #1;
      compared++; if (fifoAck !== 1'b0) begin mismatched++; $display("[TB] FAIL en_ack_comb: got %b expected 0", fifoAck); end
      enable = 1'b1;
      for (int v = 1; v <= 4; v++) srcQ.push_back(DW'(v));
      srcEn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      enable = 1'b0; rdReady = 1'b1;
      @(posedge clk); #1;
      compared++; if (fifoAck !== 1'b0) begin mismatched++; $display("[TB] FAIL en_ack_off: got %b expected 0", fifoAck); end
      compared++; if (rdValid !== 1'b1 || rdData !== DW'(2)) begin mismatched++; $display("[TB] FAIL en_drain2: got valid %b data %0h expected 1/2", rdValid, rdData); end
      repeat (3) @(posedge clk);
      #1;
      compared++; if (rdValid !== 1'b0) begin mismatched++; $display("[TB] FAIL en_empty: got %b expected 0", rdValid); end
      compared++; if (wordCount !== CW'(2)) begin mismatched++; $display("[TB] FAIL en_wcnt: got %0d expected 2", wordCount); end
      compared++; if (srcQ.size() != 2) begin mismatched++; $display("[TB] FAIL en_nopop: got %0d left in fifo expected 2", srcQ.size()); end
      enable = 1'b1;
      for (int c = 0; c < 100; c++) begin
         if (srcQ.size() == 0 && expQ.size() == 0) break;
         @(posedge clk);
      end
      #1;
      compared++; if (wordCount !== CW'(4)) begin mismatched++; $display("[TB] FAIL en_resume: got %0d expected 4", wordCount); end
      srcEn = 1'b0;
   endtask

   task automatic test_reset_midstream();
      applyReset();
      enable = 1'b1; rdReady = 1'b0;
      srcQ.push_back(32'd10); srcQ.push_back(32'd11); srcQ.push_back(32'd12);
      srcEn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      compared++; if (errCount !== CW'(SEQCHK)) begin mismatched++; $display("[TB] FAIL mid_pre_err: got %0d expected %0d", errCount, SEQCHK); end
      rst = 1'b1; srcEn = 1'b0; srcQ.delete();
      @(posedge clk); #1;
      compared++; if (rdValid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_valid: got %b expected 0", rdValid); end
      compared++; if (wordCount !== '0) begin mismatched++; $display("[TB] FAIL mid_wcnt: got %0d expected 0", wordCount); end
      compared++; if (errCount !== '0 || seqErr !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_err: got %0d/%b expected 0/0", errCount, seqErr); end
      compared++; if (fifoAck !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_ack_gate: got %b expected 0", fifoAck); end
      rst = 1'b0;
      #1;
      compared++; if (fifoAck !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_ack_release: got %b expected 1", fifoAck); end
      srcQ.push_back(32'd1); srcQ.push_back(32'd2);
      srcEn = 1'b1; rdReady = 1'b1;
      for (int c = 0; c < 100; c++) begin
         if (srcQ.size() == 0 && expQ.size() == 0) break;
         @(posedge clk);
      end
      #1;
      compared++; if (errCount !== '0 || seqErr !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_restart: got %0d/%b expected 0/0", errCount, seqErr); end
      compared++; if (wordCount !== CW'(2)) begin mismatched++; $display("[TB] FAIL mid_wcnt2: got %0d expected 2", wordCount); end
      srcEn = 1'b0;
   endtask

   task automatic test_wrap8();
      logic [7:0] vals[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      applyReset();
      enable8 = 1'b1; rdReady8 = 1'b1;
      foreach (vals[i]) begin
         fifoValid8 = 1'b1;
         fifoData8  = vals[i];
         @(posedge clk); #1;
         compared++;
         if (rdValid8 !== 1'b1 || rdData8 !== vals[i]) begin
            mismatched++;
            $display("[TB] FAIL wrap_beat: got valid %b data %0h expected 1/%0h", rdValid8, rdData8, vals[i]);
         end
      end
      fifoValid8 = 1'b0;
      @(posedge clk); #1;
      compared++; if (rdValid8 !== 1'b0) begin mismatched++; $display("[TB] FAIL wrap_end: got %b expected 0", rdValid8); end
      compared++; if (wordCount8 !== CW'(4)) begin mismatched++; $display("[TB] FAIL wrap_wcnt: got %0d expected 4", wordCount8); end
      compared++; if (seqErr8 !== 1'b0 || errCount8 !== '0) begin mismatched++; $display("[TB] FAIL wrap_err: got %b/%0d expected 0/0", seqErr8, errCount8); end
   endtask

   initial begin
      compared = 0; mismatched = 0; popCount = 0;
      srcEn = 1'b0; fifoValid = 1'b0; fifoData = '0;
      fifoValid8 = 1'b0; fifoData8 = '0;
      fork
         runScoreboard();
      join_none
      test_reset();
      test_stream();
      test_backpressure();
      test_seq_gap();
      test_enable_drop();
      test_reset_midstream();
      test_wrap8();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no finish expected finish before 100000");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
